// File: rtl/q_target_sequencer.sv
// Steps the Q control loop through a programmable table of targets: reset the loop,
// apply the target, wait for convergence or timeout, then emit one result record per point.
module q_target_sequencer #(
  parameter int BUS_WIDTH  = 10,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int RST_CYCLES = 5,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [BUS_WIDTH-1:0] cfg_data,
  input  logic [LW-1:0]        run_len,
  input  logic [CNT_WIDTH-1:0] timeout_limit,
  input  logic                 start_sweep,
  input  logic                 abort,
  input  logic                 converged,
  output logic [BUS_WIDTH-1:0] q_desired,
  output logic                 loop_rst,
  output logic                 loop_enable,
  output logic                 busy,
  output logic                 res_valid,
  output logic [AW-1:0]        res_idx,
  output logic                 res_timed_out,
  output logic [CNT_WIDTH-1:0] res_cycles,
  output logic [LW-1:0]        fail_count,
  output logic                 done,
  output logic                 aborted
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOP_RST, APPLY, WAIT_CONV, RECORD, DONE, ABORT_RST
  } state_e;

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   tbl_q [DEPTH];
  logic [LW-1:0]          len_q;
  logic [CNT_WIDTH-1:0]   tlim_q;
  logic [AW-1:0]          idx_q;
  logic [CNT_WIDTH-1:0]   wait_cnt_q;
  logic [RW-1:0]          rst_cnt_q;
  logic                   abort_pend_q;

  logic [LW-1:0]          len_clamp;
  logic [CNT_WIDTH-1:0]   cyc_now;
  logic                   conv_hit, to_hit, rst_last, last_pt;

  assign busy        = (state_q != IDLE);
  assign loop_rst    = state_q inside {LOOP_RST, ABORT_RST};
  assign loop_enable = (state_q == WAIT_CONV);
  assign res_valid   = (state_q == RECORD);

  assign len_clamp = (run_len > LW'(DEPTH)) ? LW'(DEPTH) : run_len;
  assign cyc_now   = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  // A zero count marks the first WAIT_CONV cycle, where a stale converged is blanked.
  assign conv_hit  = converged && (wait_cnt_q != '0);
  assign to_hit    = (tlim_q != '0) && (cyc_now == tlim_q);
  assign rst_last  = (rst_cnt_q == RW'(RST_CYCLES - 1));
  assign last_pt   = (LW'(idx_q) + 1'b1) >= len_q;

  // NOTE: state_d gets its default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_sweep && len_clamp != '0) state_d = LOOP_RST;
      LOOP_RST:  if (rst_last) state_d = (abort || abort_pend_q) ? ABORT_RST : APPLY;
      APPLY:     state_d = abort ? ABORT_RST : WAIT_CONV;
      WAIT_CONV: begin
        if (abort)                    state_d = ABORT_RST;
        else if (conv_hit || to_hit)  state_d = RECORD;
      end
      RECORD:    state_d = abort ? ABORT_RST : (last_pt ? DONE : LOOP_RST);
      DONE:      state_d = abort ? ABORT_RST : IDLE;
      ABORT_RST: if (rst_last) state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: the table is reset so a sweep started right after reset sees all-zero targets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (cfg_we && !busy && (int'(cfg_addr) < DEPTH)) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      tlim_q        <= '0;
      idx_q         <= '0;
      wait_cnt_q    <= '0;
      rst_cnt_q     <= '0;
      abort_pend_q  <= 1'b0;
      q_desired     <= '0;
      res_idx       <= '0;
      res_timed_out <= 1'b0;
      res_cycles    <= '0;
      fail_count    <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == DONE) ||
                 (state_q == IDLE && start_sweep && len_clamp == '0);
      aborted <= (state_d == DONE) && (state_q == ABORT_RST);

      if (loop_rst && state_d == state_q) rst_cnt_q <= rst_cnt_q + 1'b1;
      else                                rst_cnt_q <= '0;

      unique case (state_q)
        IDLE: if (start_sweep) begin
          len_q        <= len_clamp;
          tlim_q       <= timeout_limit;
          fail_count   <= '0;
          idx_q        <= '0;
          abort_pend_q <= 1'b0;
        end
        LOOP_RST: if (abort) abort_pend_q <= 1'b1;
        APPLY: begin
          q_desired  <= tbl_q[idx_q];
          wait_cnt_q <= '0;
        end
        WAIT_CONV: begin
          wait_cnt_q <= cyc_now;
          if (state_d == RECORD) begin
            res_idx       <= idx_q;
            res_cycles    <= cyc_now;
            res_timed_out <= !conv_hit;
            if (!conv_hit) fail_count <= fail_count + 1'b1;
          end
        end
        RECORD: if (state_d == LOOP_RST) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q_target_sequencer.sv
// Self-checking bench for q_target_sequencer: a loop model answers loop_enable with
// converged after a per-point latency; expected records come from plain arithmetic.
module tb_q_target_sequencer;

  localparam int BUS_WIDTH  = 10;
  localparam int DEPTH      = 4;
  localparam int CNT_WIDTH  = 16;
  localparam int RST_CYCLES = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [9:0]  cfg_data = '0;
  logic [2:0]  run_len = '0;
  logic [15:0] timeout_limit = '0;
  logic        start_sweep = 1'b0;
  logic        abort = 1'b0;
  logic        converged;
  logic [9:0]  q_desired;
  logic        loop_rst, loop_enable, busy, res_valid, res_timed_out, done, aborted;
  logic [1:0]  res_idx;
  logic [15:0] res_cycles;
  logic [2:0]  fail_count;

  int checks = 0;
  int errors = 0;
  int tbl [DEPTH];
  int conv_tab [8];
  int pt = 0;
  bit stale = 1'b0;
  int en_cnt = 0;
  int cur_k;

  q_target_sequencer #(
    .BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .run_len(run_len), .timeout_limit(timeout_limit), .start_sweep(start_sweep),
    .abort(abort), .converged(converged), .q_desired(q_desired), .loop_rst(loop_rst),
    .loop_enable(loop_enable), .busy(busy), .res_valid(res_valid), .res_idx(res_idx),
    .res_timed_out(res_timed_out), .res_cycles(res_cycles), .fail_count(fail_count),
    .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Loop model: converged rises in the k-th enabled cycle of a point and holds until loop_rst.
  always @(posedge clk) begin
    if (loop_rst)         en_cnt <= 0;
    else if (loop_enable) en_cnt <= en_cnt + 1;
  end
  always_comb cur_k = (pt >= 0 && pt < 8) ? conv_tab[pt] : 0;
  assign converged = stale || (cur_k != 0 && loop_enable && en_cnt >= cur_k - 1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Convergence in the first waiting cycle is blanked, so it is seen one cycle later.
  function automatic void exp_point(input int k, input int lim, output bit to, output int cyc);
    int c;
    c = (k == 0) ? 0 : ((k < 2) ? 2 : k);
    if (lim != 0 && (c == 0 || c > lim)) begin to = 1'b1; cyc = lim; end
    else begin to = 1'b0; cyc = c; end
  endfunction

  task automatic write_tbl(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_data = d[9:0];
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic run_sweep(input int len, input int lim);
    int exp_pts, fails, nres, first_en, rst_run, exp_cyc;
    bit fin, exp_to, prev_rst;
    exp_pts = (len > DEPTH) ? DEPTH : len;
    fails = 0; nres = 0; first_en = -1; rst_run = 0; fin = 1'b0; prev_rst = 1'b0;
    pt = 0;
    @(negedge clk);
    run_len = len[2:0]; timeout_limit = lim[15:0]; start_sweep = 1'b1;
    for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
      @(negedge clk);
      start_sweep = 1'b0;
      if (loop_enable && first_en < 0) first_en = cyc;
      if (loop_rst) rst_run++;
      else if (prev_rst) begin
        check("loop_rst_len", rst_run, RST_CYCLES);
        rst_run = 0;
      end
      prev_rst = loop_rst;
      if (res_valid) begin
        exp_point(cur_k, lim, exp_to, exp_cyc);
        if (exp_to) fails++;
        check("res_idx", res_idx, pt);
        check("res_timed_out", res_timed_out, exp_to);
        check("res_cycles", res_cycles, exp_cyc);
        check("q_desired", q_desired, tbl[pt % DEPTH]);
        check("fail_count", fail_count, fails);
        pt++; nres++;
      end
      if (done) begin
        fin = 1'b1;
        check("res_count", nres, exp_pts);
        check("aborted", aborted, 0);
        check("final_fail_count", fail_count, fails);
        if (exp_pts == 0) check("empty_done_latency", cyc, 1);
        else begin
          check("first_enable_latency", first_en, RST_CYCLES + 2);
          check("q_desired_hold", q_desired, tbl[exp_pts - 1]);
        end
      end
    end
    check("sweep_finished", fin, 1);
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int nres, rst_run, lim;
    bit got, fin;

    #1;
    check("rst_q_desired", q_desired, 0);
    check("rst_loop_rst", loop_rst, 0);
    check("rst_loop_enable", loop_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Nominal sweep, every point converges after 30 cycles.
    write_tbl(0, 50); write_tbl(1, 80); write_tbl(2, 120); write_tbl(3, 160);
    conv_tab = '{30, 30, 30, 30, 30, 30, 30, 30};
    run_sweep(4, 1000);

    // Point 2 never converges and times out; point 3 still runs.
    conv_tab = '{30, 30, 0, 30, 30, 30, 30, 30};
    run_sweep(4, 100);

    // Empty sweep and a run length clamped to the table depth.
    run_sweep(0, 100);
    conv_tab = '{12, 12, 12, 12, 12, 12, 12, 12};
    run_sweep(7, 0);

    // Convergence exactly at the timeout cycle wins; one cycle late loses.
    conv_tab = '{25, 24, 26, 25, 0, 0, 0, 0};
    run_sweep(4, 25);

    // A converged flag held high is blanked in the first waiting cycle.
    stale = 1'b1;
    conv_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_sweep(4, 0);
    stale = 1'b0;

    // Abort while idle does nothing.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);

    // Abort during point 1, with a table write attempted while busy.
    conv_tab = '{10, 0, 10, 10, 10, 10, 10, 10};
    pt = 0;
    @(negedge clk);
    run_len = 3'd4; timeout_limit = '0; start_sweep = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      start_sweep = 1'b0;
      if (res_valid) begin pt++; got = 1'b1; end
    end
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (loop_enable) got = 1'b1;
    end
    check("abort_reached_wait", got, 1);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 10'd999;
    @(negedge clk);
    cfg_we = 1'b0;
    check("busy_during_wait", busy, 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_enable_drop", loop_enable, 0);
    nres = 0; rst_run = 0; fin = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      if (res_valid) nres++;
      if (loop_rst) rst_run++;
      if (done) begin
        fin = 1'b1;
        check("abort_flag", aborted, 1);
      end
      if (!fin) @(negedge clk);
    end
    check("abort_done_seen", fin, 1);
    check("abort_rst_len", rst_run, RST_CYCLES);
    check("abort_no_res", nres, 0);

    // Table must be unchanged by the busy write.
    conv_tab = '{15, 15, 15, 15, 15, 15, 15, 15};
    run_sweep(4, 200);

    // Asynchronous reset in the middle of a wait.
    conv_tab = '{20, 20, 20, 20, 20, 20, 20, 20};
    pt = 0;
    @(negedge clk);
    run_len = 3'd4; timeout_limit = '0; start_sweep = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      start_sweep = 1'b0;
      if (res_valid) begin pt++; got = 1'b1; end
    end
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (loop_enable) got = 1'b1;
    end
    check("reset_reached_wait", got, 1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_loop_rst", loop_rst, 0);
    check("arst_loop_enable", loop_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_q_desired", q_desired, 0);
    check("arst_res_cycles", res_cycles, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_fail_count", fail_count, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) tbl[a] = 0;
    conv_tab = '{8, 8, 8, 8, 8, 8, 8, 8};
    run_sweep(4, 0);

    // Randomised sweeps against the arithmetic model.
    for (int s = 0; s < 6; s++) begin
      for (int a = 0; a < DEPTH; a++) write_tbl(a, int'($urandom_range(0, 1023)));
      lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
      for (int p = 0; p < 8; p++)
        conv_tab[p] = (lim != 0 && $urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 70));
      run_sweep(int'($urandom_range(0, 7)), lim);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
